bin2bcd_seq: RTL and testbench

//  Sequential binary-to-BCD converter (shift-add-3 / double-dabble), one bit per cycle.

---
 rtl/bcd_pkg.sv | 40 ++++
 rtl/bcd_add3_col.sv | 22 ++
 rtl/bin2bcd_seq.sv | 165 ++++++++++++++++
 tb/tb_bin2bcd_seq.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/bcd_pkg.sv
// ---------------------------------------------------------------------------
// bcd_pkg
//   Shared types and helpers for the binary-to-BCD conversion blocks.
//   - bcd_digit_t  : one packed BCD digit (0..9 in legal use)
//   - b2b_state_t  : converter FSM states
//   - add3_if_ge5  : the double-dabble digit correction step
//   - digits_fit   : elaboration-time check that DIGITS decimal digits can
//                    hold every BIN_W-bit value
// ---------------------------------------------------------------------------
package bcd_pkg;

  typedef logic [3:0] bcd_digit_t;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE
  } b2b_state_t;

  // A digit of 5..9 would become 10..18 after the coming left shift. Adding 3
  // first makes that shift carry into the next digit instead of leaving an
  // invalid code. Inputs are always 0..9, so the result fits in 4 bits.
  function automatic bcd_digit_t add3_if_ge5(bcd_digit_t d);
    return (d >= 4'd5) ? bcd_digit_t'(d + 4'd3) : d;
  endfunction

  // True when 10**digits > 2**bin_w. Scaling stops as soon as the capacity
  // passes the limit, so moderate parameter values never overflow.
  function automatic bit digits_fit(int bin_w, int digits);
    longint lim;
    longint cap;
    lim = longint'(1) << bin_w;
    cap = 1;
    for (int i = 0; (i < digits) && (cap <= lim); i++) begin
      cap = cap * 10;
    end
    return cap > lim;
  endfunction

endpackage

// File: rtl/bcd_add3_col.sv
// ---------------------------------------------------------------------------
// bcd_add3_col
//   Combinational correction column: applies add3_if_ge5 to every digit of
//   the BCD work register before the shift.
// Ports
//   din   in   4*DIGITS   packed BCD digits, digit 0 in din[3:0]
//   dout  out  4*DIGITS   corrected digits, same packing
// ---------------------------------------------------------------------------
module bcd_add3_col
  import bcd_pkg::*;
#(
  parameter int DIGITS = 4
) (
  input  logic [4*DIGITS-1:0] din,
  output logic [4*DIGITS-1:0] dout
);

  for (genvar g = 0; g < DIGITS; g++) begin : g_digit
    assign dout[4*g +: 4] = add3_if_ge5(din[4*g +: 4]);
  end

endmodule

// File: rtl/bin2bcd_seq.sv
// ---------------------------------------------------------------------------
// bin2bcd_seq
//   Sequential binary-to-BCD converter using shift-add-3 (double dabble),
//   one input bit per cycle. Feeds the seven-segment digit decoder with a
//   packed BCD code and reports how many digits are significant so the
//   anode enables can blank leading zeros.
//
//   Handshake: start is sampled only in IDLE. busy is high from the cycle
//   after accept through the done cycle. done is a one-cycle pulse; bcd and
//   ndigits are loaded on the same edge that raises done and then hold until
//   the next completed conversion.
//
// Ports
//   clk      in   1                  rising-edge clock
//   rst_n    in   1                  asynchronous active-low reset
//   start    in   1                  conversion request (IDLE only)
//   bin      in   BIN_W              binary value, captured on accept
//   busy     out  1                  conversion in progress
//   done     out  1                  result-valid pulse
//   bcd      out  4*DIGITS           packed BCD result, digit 0 = ones
//   ndigits  out  $clog2(DIGITS+1)   significant digit count, 1..DIGITS
// ---------------------------------------------------------------------------
module bin2bcd_seq
  import bcd_pkg::*;
#(
  parameter int BIN_W  = 10,
  parameter int DIGITS = 4
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         start,
  input  logic [BIN_W-1:0]             bin,
  output logic                         busy,
  output logic                         done,
  output logic [4*DIGITS-1:0]          bcd,
  output logic [$clog2(DIGITS+1)-1:0]  ndigits
);

  localparam int WORK_W = 4 * DIGITS;
  localparam int CNT_W  = $clog2(BIN_W + 1);
  localparam int ND_W   = $clog2(DIGITS + 1);
  localparam int CAT_W  = WORK_W + BIN_W;

  // The work register has no carry-out handling; that is only safe when the
  // digit count covers the full binary range.
  if (!digits_fit(BIN_W, DIGITS)) begin : g_param_check
    $error("bin2bcd_seq: DIGITS=%0d cannot hold all %0d-bit values", DIGITS, BIN_W);
  end

  b2b_state_t          state_q,   state_d;
  logic [CNT_W-1:0]    bit_cnt_q, bit_cnt_d;
  logic [BIN_W-1:0]    shift_q,   shift_d;
  logic [WORK_W-1:0]   work_q,    work_d;
  logic                busy_q,    busy_d;
  logic                done_q,    done_d;
  logic [WORK_W-1:0]   bcd_q,     bcd_d;
  logic [ND_W-1:0]     ndigits_q, ndigits_d;

  logic [WORK_W-1:0]   work_adj;
  logic [CAT_W-1:0]    cat_shl;
  logic [WORK_W-1:0]   work_shifted;
  logic [BIN_W-1:0]    shift_shifted;
  logic [ND_W-1:0]     nd_next;

  // Correction step applied to the current work digits.
  bcd_add3_col #(
    .DIGITS (DIGITS)
  ) u_add3_col (
    .din  (work_q),
    .dout (work_adj)
  );

  // {work, shift} moves left as one register: the MSB of the remaining
  // binary bits enters the ones digit. The bit shifted out of the top digit
  // is always zero because the digit count covers the full input range.
  assign cat_shl       = {work_adj, shift_q} << 1;
  assign work_shifted  = cat_shl[CAT_W-1 -: WORK_W];
  assign shift_shifted = cat_shl[BIN_W-1:0];

  // Significant digit count of the value being written into bcd: the highest
  // nonzero digit wins; an all-zero result still shows one digit.
  always_comb begin
    nd_next = ND_W'(1);
    for (int i = 0; i < DIGITS; i++) begin
      if (work_shifted[4*i +: 4] != 4'd0) begin
        nd_next = ND_W'(i + 1);
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    shift_d   = shift_q;
    work_d    = work_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    bcd_d     = bcd_q;
    ndigits_d = ndigits_q;

    case (state_q)
      IDLE: begin
        if (start) begin
          shift_d   = bin;
          work_d    = '0;
          bit_cnt_d = CNT_W'(BIN_W);
          busy_d    = 1'b1;
          state_d   = SHIFT;
        end
      end

      SHIFT: begin
        work_d    = work_shifted;
        shift_d   = shift_shifted;
        bit_cnt_d = bit_cnt_q - CNT_W'(1);
        // Last bit: publish the post-shift value on the same edge that
        // raises done, so outputs and pulse line up.
        if (bit_cnt_q == CNT_W'(1)) begin
          state_d   = DONE;
          done_d    = 1'b1;
          bcd_d     = work_shifted;
          ndigits_d = nd_next;
        end
      end

      DONE: begin
        busy_d  = 1'b0;
        state_d = IDLE;
      end

      default: begin
        busy_d  = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      bit_cnt_q <= '0;
      shift_q   <= '0;
      work_q    <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      bcd_q     <= '0;
      ndigits_q <= ND_W'(1);
    end else begin
      state_q   <= state_d;
      bit_cnt_q <= bit_cnt_d;
      shift_q   <= shift_d;
      work_q    <= work_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      bcd_q     <= bcd_d;
      ndigits_q <= ndigits_d;
    end
  end

  assign busy    = busy_q;
  assign done    = done_q;
  assign bcd     = bcd_q;
  assign ndigits = ndigits_q;

endmodule

// File: tb/tb_bin2bcd_seq.sv
// ---------------------------------------------------------------------------
// tb_bin2bcd_seq
//   Self-checking bench for bin2bcd_seq. Expected results come from decimal
//   arithmetic (division / modulo by 10), independent of the shift-add-3
//   algorithm inside the design.
// ---------------------------------------------------------------------------
module tb_bin2bcd_seq;

  localparam int BIN_W  = 10;
  localparam int DIGITS = 4;
  localparam int ND_W   = $clog2(DIGITS + 1);
  localparam int WIN    = BIN_W + 11;

  logic                 clk = 1'b0;
  logic                 rst_n;
  logic                 start;
  logic [BIN_W-1:0]     bin;
  logic                 busy;
  logic                 done;
  logic [4*DIGITS-1:0]  bcd;
  logic [ND_W-1:0]      ndigits;

  int     checks = 0;
  int     errors = 0;
  longint prev_bcd;
  longint prev_nd;

  bin2bcd_seq #(
    .BIN_W  (BIN_W),
    .DIGITS (DIGITS)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (start),
    .bin     (bin),
    .busy    (busy),
    .done    (done),
    .bcd     (bcd),
    .ndigits (ndigits)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input longint got, input longint exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, got, got, exp, exp);
    end
  endtask

  // Decimal reference: digit i is (v / 10**i) mod 10.
  function automatic longint ref_bcd(int v);
    longint r;
    int     t;
    r = 0;
    t = v;
    for (int i = 0; i < DIGITS; i++) begin
      r = r | (longint'(t % 10) << (4 * i));
      t = t / 10;
    end
    return r;
  endfunction

  // Number of decimal digits needed to write v (0 is written as one digit).
  function automatic longint ref_nd(int v);
    longint n;
    int     t;
    n = 1;
    t = v / 10;
    while (t > 0) begin
      n++;
      t = t / 10;
    end
    return n;
  endfunction

  // One conversion observed over a fixed window of WIN cycles after accept.
  // poke=1 drives extra start pulses (bin=7) during SHIFT and in the DONE
  // cycle; otherwise bin is scrambled after accept.
  task automatic run_conv(input int v, input bit poke);
    int     done_at;
    int     done_cnt;
    int     busy_cnt;
    int     hold_bad;
    int     bad_digit;
    longint got_bcd;
    longint got_nd;
    longint exp_b;
    longint exp_n;
    exp_b = ref_bcd(v);
    exp_n = ref_nd(v);
    @(negedge clk);
    bin   = BIN_W'(v);
    start = 1'b1;
    @(posedge clk);
    #1;
    start     = 1'b0;
    done_at   = 0;
    done_cnt  = 0;
    busy_cnt  = 0;
    hold_bad  = 0;
    bad_digit = 0;
    got_bcd   = -1;
    got_nd    = -1;
    for (int i = 0; i < WIN; i++) begin
      if (i > 0) begin
        @(posedge clk);
        #1;
      end
      if (busy) busy_cnt++;
      if (done) begin
        done_cnt++;
        if (done_at == 0) begin
          done_at = i + 1;
          got_bcd = longint'(bcd);
          got_nd  = longint'(ndigits);
          for (int d = 0; d < DIGITS; d++) begin
            if (bcd[4*d +: 4] > 4'd9) bad_digit++;
          end
        end
      end
      if ((done_at == 0) && ((longint'(bcd) != prev_bcd) || (longint'(ndigits) != prev_nd))) begin
        hold_bad++;
      end
      if (poke) begin
        start = (i == 3) || (i == 4) || (i == BIN_W);
        if (start) bin = BIN_W'(7);
      end else begin
        start = 1'b0;
        bin   = BIN_W'($urandom);
      end
    end
    start = 1'b0;
    check_eq("latency", done_at, BIN_W + 1);
    check_eq("done_pulses", done_cnt, 1);
    check_eq("busy_len", busy_cnt, BIN_W + 1);
    check_eq("hold_before_done", hold_bad, 0);
    check_eq("digit_range", bad_digit, 0);
    check_eq("bcd", got_bcd, exp_b);
    check_eq("ndigits", got_nd, exp_n);
    check_eq("bcd_after", longint'(bcd), exp_b);
    prev_bcd = exp_b;
    prev_nd  = exp_n;
  endtask

  initial begin
    int dcnt;
    rst_n = 1'b0;
    start = 1'b0;
    bin   = '0;
    prev_bcd = 0;
    prev_nd  = 1;
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_busy", busy, 0);
    check_eq("rst_done", done, 0);
    check_eq("rst_bcd", bcd, 0);
    check_eq("rst_ndigits", ndigits, 1);
    @(negedge clk);
    rst_n = 1'b1;

    // Directed values
    run_conv(0, 1'b0);
    check_eq("dir_0", bcd, 'h0000);
    run_conv(1023, 1'b0);
    check_eq("dir_1023", bcd, 'h1023);
    check_eq("dir_1023_nd", ndigits, 4);
    run_conv(99, 1'b0);
    check_eq("dir_99", bcd, 'h0099);
    check_eq("dir_99_nd", ndigits, 2);
    run_conv(100, 1'b0);
    check_eq("dir_100", bcd, 'h0100);
    check_eq("dir_100_nd", ndigits, 3);

    // Starts during SHIFT and DONE are ignored
    run_conv(512, 1'b1);
    check_eq("ignore_start", bcd, 'h0512);

    // Old result holds while the next conversion runs
    run_conv(999, 1'b0);
    run_conv(5, 1'b0);
    check_eq("dir_5", bcd, 'h0005);
    check_eq("dir_5_nd", ndigits, 1);

    // Reset in the middle of a conversion
    @(negedge clk);
    bin   = BIN_W'(777);
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check_eq("midrst_busy", busy, 0);
    check_eq("midrst_done", done, 0);
    check_eq("midrst_bcd", bcd, 0);
    check_eq("midrst_ndigits", ndigits, 1);
    @(negedge clk);
    rst_n = 1'b1;
    dcnt = 0;
    for (int i = 0; i < 2 * WIN; i++) begin
      @(posedge clk);
      #1;
      if (done || busy) dcnt++;
    end
    check_eq("no_done_after_rst", dcnt, 0);
    prev_bcd = 0;
    prev_nd  = 1;
    run_conv(42, 1'b0);
    check_eq("dir_42", bcd, 'h0042);

    // Full input range
    for (int v = 0; v < (1 << BIN_W); v++) begin
      run_conv(v, 1'b0);
    end

    // Random values, randomly with ignored start pulses
    for (int k = 0; k < 150; k++) begin
      run_conv(int'($urandom_range(0, (1 << BIN_W) - 1)), bit'($urandom_range(0, 1)));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
